// File: rtl/imem_boot_loader.sv
// imem_boot_loader: boot-time instruction memory loader.
// Packs a little-endian byte stream (valid/ready) into 32-bit words and writes
// them to sequential word-aligned imem addresses while holding the CPU.
module imem_boot_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 512,
    parameter int LEN_W      = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [LEN_W-1:0]      load_len,
    input  logic                  load_abort,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(MEM_SIZE);

    state_t                 state;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       word_idx;
    logic [1:0]             byte_cnt;
    logic [DATA_WIDTH-1:0]  word_q;
    logic                   err_q;
    logic                   len_ok;
    logic                   last_word;

    assign len_ok    = (load_len != '0) && ({1'b0, load_len} <= MAX_LEN);
    assign last_word = (word_idx == (len_q - LEN_W'(1)));

    // Load sequencing: length check, byte packing, word write, completion/abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            len_q    <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            word_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        if (len_ok) begin
                            len_q    <= load_len;
                            word_idx <= '0;
                            byte_cnt <= '0;
                            state    <= RECV;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (load_abort) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else if (in_valid) begin
                        word_q[{byte_cnt, 3'b000} +: 8] <= in_byte;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (load_abort) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else if (last_word) begin
                        state <= DONE;
                    end else begin
                        word_idx <= word_idx + LEN_W'(1);
                        state    <= RECV;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode; an abort in the WRITE cycle masks the strobe so no partial load lands.
    always_comb begin
        in_ready  = (state == RECV);
        wr_en     = (state == WRITE) && !load_abort;
        cpu_hold  = (state != IDLE);
        load_done = (state == DONE);
        load_err  = err_q;
        wr_data   = word_q;
        wr_addr   = '0;
        wr_addr[LEN_W+1:0] = {word_idx, 2'b00};
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: cycle model plus directed loads.
module tb_imem_boot_loader;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic [9:0]  load_len;
    logic        load_abort;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int checks;
    int failures;
    int cyc;
    int start_cyc;
    int done_cyc;
    int done_cnt;
    int err_cnt;
    logic [31:0] max_addr;
    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];

    // model: word-level bookkeeping of the load in progress
    int          m_active;
    int          m_got;
    int          m_widx;
    int          m_len;
    int          m_fin;
    int          m_err;
    int          m_was_fin;
    logic [31:0] m_buf;

    imem_boot_loader #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MEM_SIZE  (512),
        .LEN_W     (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_start(load_start),
        .load_len  (load_len),
        .load_abort(load_abort),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a load is "active" until its last word is written; within a
    // word, 4 bytes are gathered, then one write cycle follows.
    initial begin
        m_active = 0; m_got = 0; m_widx = 0; m_len = 0; m_fin = 0; m_err = 0; m_buf = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_active = 0; m_got = 0; m_widx = 0; m_fin = 0; m_err = 0; m_buf = '0;
            end else begin
                m_was_fin = m_fin;
                m_fin = 0;
                m_err = 0;
                if (m_active != 0) begin
                    if (load_abort) begin
                        m_active = 0;
                        m_err = 1;
                    end else if (m_got == 4) begin
                        if (m_widx == m_len - 1) begin
                            m_active = 0;
                            m_fin = 1;
                        end else begin
                            m_widx++;
                            m_got = 0;
                        end
                    end else if (in_valid) begin
                        m_buf[8*m_got +: 8] = in_byte;
                        m_got++;
                    end
                end else if (m_was_fin == 0 && load_start) begin
                    if (load_len >= 1 && load_len <= 512) begin
                        m_active = 1;
                        m_len = int'(load_len);
                        m_widx = 0;
                        m_got = 0;
                    end else begin
                        m_err = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus logging of observed activity.
    initial begin
        logic exp_wr;
        forever begin
            @(negedge clk);
            exp_wr = (m_active != 0) && (m_got == 4) && !load_abort;
            chk("in_ready", in_ready, (m_active != 0 && m_got < 4));
            chk("wr_en", wr_en, exp_wr);
            chk("cpu_hold", cpu_hold, (m_active != 0 || m_fin != 0));
            chk("load_done", load_done, (m_fin != 0));
            chk("load_err", load_err, (m_err != 0));
            if (exp_wr) begin
                chk("wr_addr", wr_addr, 32'(m_widx * 4));
                chk("wr_data", wr_data, m_buf);
            end
            if (wr_en) begin
                wlog_addr.push_back(wr_addr);
                wlog_data.push_back(wr_data);
                if (wr_addr > max_addr) max_addr = wr_addr;
            end
            if (load_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (load_err) err_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int len);
        load_start = 1'b1;
        load_len   = 10'(len);
        start_cyc  = cyc;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bubble);
        bit acc;
        int n;
        n = 0;
        acc = 1'b0;
        in_byte  = b;
        in_valid = 1'b1;
        while (!acc && n < 16) begin
            acc = in_ready;
            tick();
            n++;
        end
        chk("byte_accept_timeout", acc, 1);
        in_valid = 1'b0;
        if (bubble) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input bit bubble);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], bubble);
    endtask

    task automatic clear_log();
        wlog_addr.delete();
        wlog_data.delete();
        max_addr = '0;
    endtask

    logic [7:0] two_word[8];
    int err_base;
    int done_base;

    initial begin
        checks = 0; failures = 0; cyc = 0; done_cnt = 0; err_cnt = 0; done_cyc = 0;
        max_addr = '0;
        two_word = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        reset = 1'b1; load_start = 1'b0; load_len = '0; load_abort = 1'b0;
        in_byte = '0; in_valid = 1'b0;
        tick(); tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        reset = 1'b0;
        tick();

        // 2-word load, back-to-back bytes
        clear_log();
        done_base = done_cnt;
        start_load(2);
        chk("hold_after_start", cpu_hold, 1);
        for (int i = 0; i < 8; i++) send_byte(two_word[i], 1'b0);
        tick(); tick(); tick();
        chk("t1_nwrites", wlog_addr.size(), 2);
        if (wlog_addr.size() == 2) begin
            chk("t1_addr0", wlog_addr[0], 32'h0);
            chk("t1_data0", wlog_data[0], 32'h00500513);
            chk("t1_addr1", wlog_addr[1], 32'h4);
            chk("t1_data1", wlog_data[1], 32'h00100593);
        end
        chk("t1_done_cnt", done_cnt - done_base, 1);
        chk("t1_done_latency", done_cyc - start_cyc, 11);
        chk("t1_hold_released", cpu_hold, 0);

        // same bytes with a bubble after every byte
        clear_log();
        start_load(2);
        for (int i = 0; i < 8; i++) send_byte(two_word[i], 1'b1);
        tick(); tick(); tick();
        chk("t2_nwrites", wlog_addr.size(), 2);
        if (wlog_addr.size() == 2) begin
            chk("t2_data0", wlog_data[0], 32'h00500513);
            chk("t2_addr1", wlog_addr[1], 32'h4);
            chk("t2_data1", wlog_data[1], 32'h00100593);
        end

        // bad lengths
        clear_log();
        err_base = err_cnt;
        start_load(0);
        chk("t3_hold_len0", cpu_hold, 0);
        tick(); tick();
        start_load(513);
        chk("t3_hold_len513", cpu_hold, 0);
        tick(); tick();
        chk("t3_err_cnt", err_cnt - err_base, 2);
        chk("t3_nwrites", wlog_addr.size(), 0);

        // abort after two bytes, then a fresh one-word load
        clear_log();
        err_base = err_cnt;
        start_load(2);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        chk("t4_idle_after_abort", cpu_hold, 0);
        tick();
        chk("t4_err_cnt", err_cnt - err_base, 1);
        chk("t4_nwrites", wlog_addr.size(), 0);
        start_load(1);
        send_word(32'hDDCCBBAA, 1'b0);
        tick(); tick(); tick();
        chk("t4_nwrites_after", wlog_addr.size(), 1);
        if (wlog_addr.size() == 1) begin
            chk("t4_addr", wlog_addr[0], 32'h0);
            chk("t4_data", wlog_data[0], 32'hDDCCBBAA);
        end

        // abort landing in the write cycle
        clear_log();
        err_base = err_cnt;
        done_base = done_cnt;
        start_load(1);
        send_word(32'h12345678, 1'b0);
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        tick(); tick();
        chk("t4b_nwrites", wlog_addr.size(), 0);
        chk("t4b_err_cnt", err_cnt - err_base, 1);
        chk("t4b_done_cnt", done_cnt - done_base, 0);

        // full fill
        clear_log();
        done_base = done_cnt;
        start_load(512);
        for (int i = 0; i < 512; i++) send_word(32'hA0000000 + 32'(i), 1'b0);
        tick(); tick(); tick();
        chk("t5_nwrites", wlog_addr.size(), 512);
        if (wlog_addr.size() == 512) begin
            chk("t5_last_addr", wlog_addr[511], 32'h7FC);
            chk("t5_last_data", wlog_data[511], 32'hA00001FF);
        end
        chk("t5_max_addr", max_addr, 32'h7FC);
        chk("t5_done_cnt", done_cnt - done_base, 1);

        // reset asserted during a write cycle
        clear_log();
        start_load(2);
        send_word(32'hCAFEF00D, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("t6_wr_en", wr_en, 0);
        chk("t6_cpu_hold", cpu_hold, 0);
        chk("t6_in_ready", in_ready, 0);
        chk("t6_wr_addr", wr_addr, 0);
        chk("t6_wr_data", wr_data, 0);
        chk("t6_done", load_done, 0);
        chk("t6_err", load_err, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_nwrites_reset", wlog_addr.size(), 0);
        start_load(1);
        send_word(32'h04030201, 1'b0);
        tick(); tick(); tick();
        chk("t6_nwrites", wlog_addr.size(), 1);
        if (wlog_addr.size() == 1) begin
            chk("t6_addr", wlog_addr[0], 32'h0);
            chk("t6_data", wlog_data[0], 32'h04030201);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
